// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
// Bit-serial adder/subtractor sequencer. Two WIDTH-bit operands are latched
// on an accepted start and fed LSB-first, one bit per clock, through a single
// 1-bit add/sub cell. The carry/borrow between bits lives in a flop, and the
// result is assembled in a right-shifting register. The result and the final
// carry/borrow are published when the last bit is processed. They are then
// held until the next accepted start.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             modeAddSubtract,
  input  logic             modeHalfFull,
  input  logic             carryborrowIn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sumdiff,
  output logic             carryborrowOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic             r_cb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sumdiff;
  logic             r_cbo;

  logic             w_x;
  logic             w_y;
  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // One-bit add/sub cell. With mode=1, the cout term becomes the borrow of x-y-c.
  assign w_x       = r_op_a[0];
  assign w_y       = r_op_b[0];
  assign w_s       = w_x ^ w_y ^ r_cb;
  assign w_cout    = (r_cb & (w_x ^ w_y ^ r_mode)) | ((w_x ^ r_mode) & w_y);
  assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST_BIT);

  // State register; the reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Start is only honoured in IDLE, and requests are never queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  // Operand latch, serial shifting, carry flop, bit counter and result publish.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_op_a    <= {WIDTH{1'b0}};
      r_op_b    <= {WIDTH{1'b0}};
      r_res     <= {WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_mode    <= 1'b0;
      r_cb      <= 1'b0;
      r_sumdiff <= {WIDTH{1'b0}};
      r_cbo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a    <= a;
            r_op_b    <= b;
            r_mode    <= modeAddSubtract;
            // HALF mode forces the initial carry/borrow to zero.
            r_cb      <= carryborrowIn & modeHalfFull;
            r_res     <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_sumdiff <= {WIDTH{1'b0}};
            r_cbo     <= 1'b0;
          end else begin
            r_cnt     <= r_cnt;
          end
        end
        S_RUN: begin
          r_op_a <= {1'b0, r_op_a[WIDTH-1:1]};
          r_op_b <= {1'b0, r_op_b[WIDTH-1:1]};
          r_res  <= w_res_nxt;
          r_cb   <= w_cout;
          if (w_last) begin
            r_sumdiff <= w_res_nxt;
            r_cbo     <= w_cout;
            r_cnt     <= r_cnt;
          end else begin
            r_cnt     <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign sumdiff        = r_sumdiff;
  assign carryborrowOut = r_cbo;

endmodule
